// File: rtl/dsp_pool_pkg.sv
// Opcodes, default widths and an index-width helper shared by the dsp_pool files.
package dsp_pool_pkg;
    localparam logic [1:0] DSP_OP_MUL  = 2'd0;  // P = A*B
    localparam logic [1:0] DSP_OP_MAC  = 2'd1;  // P = A*B + C
    localparam logic [1:0] DSP_OP_MSUB = 2'd2;  // P = C - A*B
    localparam logic [1:0] DSP_OP_NMUL = 2'd3;  // P = -A*B

    localparam int DEF_CLIENTS_N = 4;
    localparam int DEF_ALUS_N    = 2;
    localparam int DEF_CH_N      = 2;
    localparam int DEF_A_W       = 18;
    localparam int DEF_B_W       = 18;
    localparam int DEF_C_W       = 48;
    localparam int DEF_P_W       = 48;
    localparam int DEF_LAT       = 3;
    localparam int DEF_OP_W      = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/dsp_pool_lane.sv
// One multiply-add lane: CH_N pipes, valid shift register, outstanding counter, owner.
// DSP_POOL_SATURATE_EN adds a clamp stage and a sticky saturation flag.
module dsp_pool_lane
    import dsp_pool_pkg::*;
#(
    parameter int CLIENTS_N = DEF_CLIENTS_N,
    parameter int CH_N      = DEF_CH_N,
    parameter int A_W       = DEF_A_W,
    parameter int B_W       = DEF_B_W,
    parameter int C_W       = DEF_C_W,
    parameter int P_W       = DEF_P_W,
    parameter int LAT       = DEF_LAT,
    parameter int OP_W      = DEF_OP_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 grant,
    input  logic [CLIENTS_N-1:0] grant_client,
    input  logic                 cycle,
    input  logic                 strobe,
    input  logic [OP_W-1:0]      op,
    input  logic [A_W*CH_N-1:0]  a,
    input  logic [B_W*CH_N-1:0]  b,
    input  logic [C_W*CH_N-1:0]  c,
    output logic                 busy,
    output logic                 active,
    output logic [CLIENTS_N-1:0] owner,
    output logic                 ack,
    output logic [P_W*CH_N-1:0]  p
);
`ifdef DSP_POOL_SATURATE_EN
    localparam int DEPTH = LAT + 1;
    localparam int SUM_W = P_W + 1;
`else
    localparam int DEPTH = LAT;
    localparam int SUM_W = P_W;
`endif
    localparam int PR_W  = A_W + B_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                    draining;
    logic [DEPTH-1:0]        vld_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    accept;
    logic                    retire;
    logic signed [PR_W-1:0]  prod_q [CH_N];
    logic signed [C_W-1:0]   c_q [CH_N];
    logic [OP_W-1:0]         op_q;
    logic signed [SUM_W-1:0] sum_d [CH_N];
    logic [P_W*CH_N-1:0]     res_d;
    logic [P_W*CH_N-1:0]     pipe_q [LAT-1];

    function automatic logic signed [SUM_W-1:0] ext_prod(input logic signed [PR_W-1:0] x);
        return SUM_W'(x);
    endfunction

    function automatic logic signed [SUM_W-1:0] ext_c(input logic signed [C_W-1:0] x);
        return SUM_W'(x);
    endfunction

    // A draining lane keeps retiring its in-flight results but never shows them.
    assign active = busy & ~draining;
    assign accept = active & cycle & strobe;
    assign retire = vld_q[DEPTH-1];
    assign ack    = retire & active & cycle;
    assign p      = ack ? pipe_q[LAT-2] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            draining <= 1'b0;
            owner    <= '0;
            vld_q    <= '0;
            cnt_q    <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], accept};
            cnt_q <= cnt_q + CNT_W'(accept) - CNT_W'(retire);
            if (grant) begin
                busy     <= 1'b1;
                owner    <= grant_client;
                draining <= 1'b0;
            end else if (busy && (draining || !cycle) && cnt_q == '0) begin
                busy     <= 1'b0;
                owner    <= '0;
                draining <= 1'b0;
            end else if (busy && !cycle) begin
                draining <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        op_q <= op;
        for (int ch = 0; ch < CH_N; ch++) begin
            prod_q[ch] <= PR_W'($signed(a[ch*A_W +: A_W])) * PR_W'($signed(b[ch*B_W +: B_W]));
            c_q[ch]    <= $signed(c[ch*C_W +: C_W]);
        end
    end

    always_comb begin
        for (int ch = 0; ch < CH_N; ch++) begin
            sum_d[ch] = '0;
            case (op_q)
                OP_W'(DSP_OP_MUL):  sum_d[ch] = ext_prod(prod_q[ch]);
                OP_W'(DSP_OP_MAC):  sum_d[ch] = ext_c(c_q[ch]) + ext_prod(prod_q[ch]);
                OP_W'(DSP_OP_MSUB): sum_d[ch] = ext_c(c_q[ch]) - ext_prod(prod_q[ch]);
                default:            sum_d[ch] = -ext_prod(prod_q[ch]);
            endcase
        end
    end

`ifdef DSP_POOL_SATURATE_EN
    logic signed [SUM_W-1:0] sum_q [CH_N];
    logic [CH_N-1:0]         ovf;
    logic                    sat_q;

    always_ff @(posedge clk) begin
        for (int ch = 0; ch < CH_N; ch++) sum_q[ch] <= sum_d[ch];
    end

    // Clamp when the guard bit disagrees with the result sign bit.
    always_comb begin
        res_d = '0;
        ovf   = '0;
        for (int ch = 0; ch < CH_N; ch++) begin
            ovf[ch] = sum_q[ch][P_W] ^ sum_q[ch][P_W-1];
            if (!ovf[ch])
                res_d[ch*P_W +: P_W] = sum_q[ch][P_W-1:0];
            else if (sum_q[ch][P_W])
                res_d[ch*P_W +: P_W] = {1'b1, {(P_W-1){1'b0}}};
            else
                res_d[ch*P_W +: P_W] = {1'b0, {(P_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !busy) sat_q <= 1'b0;
        else if (vld_q[1] && |ovf) sat_q <= 1'b1;
    end
`else
    always_comb begin
        res_d = '0;
        for (int ch = 0; ch < CH_N; ch++) res_d[ch*P_W +: P_W] = sum_d[ch];
    end
`endif

    always_ff @(posedge clk) begin
        pipe_q[0] <= res_d;
        for (int s = 1; s < LAT-1; s++) pipe_q[s] <= pipe_q[s-1];
    end
endmodule

// File: rtl/dsp_pool.sv
// Pool of ALUS_N multiply-add lanes shared by CLIENTS_N clients through a round-robin arbiter.
// Build option DSP_POOL_SATURATE_EN (see dsp_pool_lane) selects clamping instead of wrap.
module dsp_pool
    import dsp_pool_pkg::*;
#(
    parameter int CLIENTS_N = DEF_CLIENTS_N,
    parameter int ALUS_N    = DEF_ALUS_N,
    parameter int CH_N      = DEF_CH_N,
    parameter int A_W       = DEF_A_W,
    parameter int B_W       = DEF_B_W,
    parameter int C_W       = DEF_C_W,
    parameter int P_W       = DEF_P_W,
    parameter int LAT       = DEF_LAT,
    parameter int OP_W      = DEF_OP_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CLIENTS_N-1:0]          client_cycle,
    input  logic [CLIENTS_N-1:0]          client_strobe,
    output logic [CLIENTS_N-1:0]          client_stall,
    output logic [CLIENTS_N-1:0]          client_ack,
    input  logic [OP_W*CLIENTS_N-1:0]     client_op,
    input  logic [A_W*CH_N*CLIENTS_N-1:0] client_a,
    input  logic [B_W*CH_N*CLIENTS_N-1:0] client_b,
    input  logic [C_W*CH_N*CLIENTS_N-1:0] client_c,
    output logic [P_W*CH_N*CLIENTS_N-1:0] client_p,
    output logic [ALUS_N-1:0]             lanes_busy
);
    localparam int CI_W = idx_w(CLIENTS_N);
    localparam int LI_W = idx_w(ALUS_N);

    logic [ALUS_N-1:0]    lane_busy, lane_active, lane_ack, lane_grant;
    logic [ALUS_N-1:0]    lane_cycle, lane_strobe;
    logic [CLIENTS_N-1:0] lane_owner [ALUS_N];
    logic [OP_W-1:0]      lane_op [ALUS_N];
    logic [A_W*CH_N-1:0]  lane_a [ALUS_N];
    logic [B_W*CH_N-1:0]  lane_b [ALUS_N];
    logic [C_W*CH_N-1:0]  lane_c [ALUS_N];
    logic [P_W*CH_N-1:0]  lane_p [ALUS_N];
    logic [CLIENTS_N-1:0] has_lane, cand, grant_client;
    logic [CI_W-1:0]      rr_ptr, pick;
    logic [LI_W-1:0]      free_idx;
    logic                 pick_vld, free_vld;

    // rr_ptr is the first client to consider; it moves to one past each grant.
    always_comb begin
        has_lane = '0;
        for (int l = 0; l < ALUS_N; l++)
            for (int c = 0; c < CLIENTS_N; c++)
                has_lane[c] = has_lane[c] | (lane_active[l] & lane_owner[l][c]);
        cand     = client_cycle & ~has_lane;
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = 0; i < CLIENTS_N; i++) begin
            if (!pick_vld && cand[(int'(rr_ptr) + i) % CLIENTS_N]) begin
                pick_vld = 1'b1;
                pick     = CI_W'((int'(rr_ptr) + i) % CLIENTS_N);
            end
        end
        free_vld = 1'b0;
        free_idx = '0;
        for (int l = ALUS_N - 1; l >= 0; l--) begin
            if (!lane_busy[l]) begin
                free_vld = 1'b1;
                free_idx = LI_W'(l);
            end
        end
        grant_client = pick_vld ? (CLIENTS_N'(1) << pick) : '0;
        lane_grant   = '0;
        if (pick_vld && free_vld) lane_grant[free_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) rr_ptr <= '0;
        else if (pick_vld && free_vld)
            rr_ptr <= (pick == CI_W'(CLIENTS_N - 1)) ? '0 : pick + CI_W'(1);
    end

    always_comb begin
        for (int l = 0; l < ALUS_N; l++) begin
            lane_cycle[l]  = 1'b0;
            lane_strobe[l] = 1'b0;
            lane_op[l]     = '0;
            lane_a[l]      = '0;
            lane_b[l]      = '0;
            lane_c[l]      = '0;
            for (int c = 0; c < CLIENTS_N; c++) begin
                if (lane_owner[l][c]) begin
                    lane_cycle[l]  = lane_cycle[l] | client_cycle[c];
                    lane_strobe[l] = lane_strobe[l] | client_strobe[c];
                    lane_op[l]     = lane_op[l] | client_op[c*OP_W +: OP_W];
                    lane_a[l]      = lane_a[l] | client_a[c*A_W*CH_N +: A_W*CH_N];
                    lane_b[l]      = lane_b[l] | client_b[c*B_W*CH_N +: B_W*CH_N];
                    lane_c[l]      = lane_c[l] | client_c[c*C_W*CH_N +: C_W*CH_N];
                end
            end
        end
    end

    // Lanes already zero p and ack unless showing a result, so an OR merge is safe.
    always_comb begin
        client_ack = '0;
        client_p   = '0;
        for (int l = 0; l < ALUS_N; l++) begin
            for (int c = 0; c < CLIENTS_N; c++) begin
                if (lane_owner[l][c]) begin
                    client_ack[c] = client_ack[c] | lane_ack[l];
                    client_p[c*P_W*CH_N +: P_W*CH_N] = client_p[c*P_W*CH_N +: P_W*CH_N] | lane_p[l];
                end
            end
        end
    end

    assign client_stall = ~has_lane | ~client_cycle;
    assign lanes_busy   = lane_busy;

    for (genvar l = 0; l < ALUS_N; l++) begin : g_lane
        dsp_pool_lane #(
            .CLIENTS_N(CLIENTS_N), .CH_N(CH_N), .A_W(A_W), .B_W(B_W),
            .C_W(C_W), .P_W(P_W), .LAT(LAT), .OP_W(OP_W)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .grant        (lane_grant[l]),
            .grant_client (grant_client),
            .cycle        (lane_cycle[l]),
            .strobe       (lane_strobe[l]),
            .op           (lane_op[l]),
            .a            (lane_a[l]),
            .b            (lane_b[l]),
            .c            (lane_c[l]),
            .busy         (lane_busy[l]),
            .active       (lane_active[l]),
            .owner        (lane_owner[l]),
            .ack          (lane_ack[l]),
            .p            (lane_p[l])
        );
    end
endmodule

// File: tb/tb_dsp_pool.sv
// Directed bench for dsp_pool: reset, single request, arbitration, burst, drop/flush, wrap/saturate, reset mid-burst.
module tb_dsp_pool;
    localparam int CLIENTS_N = 4;
    localparam int ALUS_N    = 2;
    localparam int CH_N      = 2;
    localparam int A_W       = 18;
    localparam int B_W       = 18;
    localparam int C_W       = 48;
    localparam int P_W       = 48;
    localparam int LAT       = 3;
    localparam int OP_W      = 2;
`ifdef DSP_POOL_SATURATE_EN
    localparam int DEPTH = LAT + 1;
`else
    localparam int DEPTH = LAT;
`endif

    logic                          clk = 1'b0;
    logic                          reset;
    logic [CLIENTS_N-1:0]          client_cycle, client_strobe, client_stall, client_ack;
    logic [OP_W*CLIENTS_N-1:0]     client_op;
    logic [A_W*CH_N*CLIENTS_N-1:0] client_a;
    logic [B_W*CH_N*CLIENTS_N-1:0] client_b;
    logic [C_W*CH_N*CLIENTS_N-1:0] client_c;
    logic [P_W*CH_N*CLIENTS_N-1:0] client_p;
    logic [ALUS_N-1:0]             lanes_busy;

    int errors = 0;
    int checks = 0;

    dsp_pool #(
        .CLIENTS_N(CLIENTS_N), .ALUS_N(ALUS_N), .CH_N(CH_N), .A_W(A_W), .B_W(B_W),
        .C_W(C_W), .P_W(P_W), .LAT(LAT), .OP_W(OP_W)
    ) dut (
        .clk(clk), .reset(reset), .client_cycle(client_cycle), .client_strobe(client_strobe),
        .client_stall(client_stall), .client_ack(client_ack), .client_op(client_op),
        .client_a(client_a), .client_b(client_b), .client_c(client_c), .client_p(client_p),
        .lanes_busy(lanes_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int cl, input int op, input longint a0, input longint b0, input longint c0,
                           input longint a1, input longint b1, input longint c1);
        client_op[cl*OP_W +: OP_W]         = OP_W'(op);
        client_a[(cl*CH_N)*A_W +: A_W]     = A_W'(a0);
        client_a[(cl*CH_N + 1)*A_W +: A_W] = A_W'(a1);
        client_b[(cl*CH_N)*B_W +: B_W]     = B_W'(b0);
        client_b[(cl*CH_N + 1)*B_W +: B_W] = B_W'(b1);
        client_c[(cl*CH_N)*C_W +: C_W]     = C_W'(c0);
        client_c[(cl*CH_N + 1)*C_W +: C_W] = C_W'(c1);
    endtask

    function automatic logic [P_W-1:0] p_of(input int cl, input int ch);
        return client_p[(cl*CH_N + ch)*P_W +: P_W];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        client_cycle = '0; client_strobe = '0;
        client_op = '0; client_a = '0; client_b = '0; client_c = '0;
        tick(); tick();
        checks++; if (client_stall !== 4'hF) begin errors++; $display("FAIL reset_stall: got %b want 1111", client_stall); end
        checks++; if (client_ack !== 4'h0) begin errors++; $display("FAIL reset_ack: got %b want 0000", client_ack); end
        checks++; if (client_p !== '0) begin errors++; $display("FAIL reset_p: got %h want 0", client_p); end
        checks++; if (lanes_busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", lanes_busy); end
        reset = 1'b0;
        tick();
        checks++; if (client_stall !== 4'hF) begin errors++; $display("FAIL idle_stall: got %b want 1111", client_stall); end
    endtask

    task automatic test_single();
        client_cycle[0] = 1'b1;
        tick();
        checks++; if (client_stall !== 4'b1110) begin errors++; $display("FAIL single_grant_stall: got %b want 1110", client_stall); end
        checks++; if (lanes_busy !== 2'b01) begin errors++; $display("FAIL single_grant_busy: got %b want 01", lanes_busy); end
        set_req(0, 1, 3, -4, 100, 3, -4, 100);
        client_strobe[0] = 1'b1;
        tick();
        client_strobe[0] = 1'b0;
        checks++; if (client_ack !== 4'h0) begin errors++; $display("FAIL single_ack_t1: got %b want 0000", client_ack); end
        tick();
        checks++; if (client_ack !== 4'h0) begin errors++; $display("FAIL single_ack_t2: got %b want 0000", client_ack); end
        tick();
        checks++; if (client_ack !== 4'b0001) begin errors++; $display("FAIL single_ack_t3: got %b want 0001", client_ack); end
        checks++; if (p_of(0, 0) !== 48'd88) begin errors++; $display("FAIL single_p_ch0: got %0d want 88", $signed(p_of(0, 0))); end
        checks++; if (p_of(0, 1) !== 48'd88) begin errors++; $display("FAIL single_p_ch1: got %0d want 88", $signed(p_of(0, 1))); end
        checks++; if (p_of(1, 0) !== 48'd0) begin errors++; $display("FAIL unlocked_p: got %h want 0", p_of(1, 0)); end
        tick();
        checks++; if (client_ack !== 4'h0) begin errors++; $display("FAIL single_ack_t4: got %b want 0000", client_ack); end
        client_cycle[0] = 1'b0;
        tick();
        checks++; if (lanes_busy !== 2'b00) begin errors++; $display("FAIL single_free: got %b want 00", lanes_busy); end
    endtask

    task automatic test_arbitration();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        client_cycle = 4'hF;
        tick();
        checks++; if (lanes_busy !== 2'b01 || client_stall !== 4'b1110) begin errors++; $display("FAIL arb_grant0: got busy=%b stall=%b want 01/1110", lanes_busy, client_stall); end
        tick();
        checks++; if (lanes_busy !== 2'b11 || client_stall !== 4'b1100) begin errors++; $display("FAIL arb_grant1: got busy=%b stall=%b want 11/1100", lanes_busy, client_stall); end
        tick();
        checks++; if (client_stall !== 4'b1100) begin errors++; $display("FAIL arb_wait: got %b want 1100", client_stall); end
        client_cycle[0] = 1'b0;
        tick();
        checks++; if (lanes_busy !== 2'b10 || client_stall !== 4'b1101) begin errors++; $display("FAIL arb_free: got busy=%b stall=%b want 10/1101", lanes_busy, client_stall); end
        tick();
        checks++; if (lanes_busy !== 2'b11 || client_stall !== 4'b1001) begin errors++; $display("FAIL arb_rr_next: got busy=%b stall=%b want 11/1001", lanes_busy, client_stall); end
        client_cycle = '0;
        tick(); tick();
        checks++; if (lanes_busy !== 2'b00) begin errors++; $display("FAIL arb_release: got %b want 00", lanes_busy); end
    endtask

    task automatic test_burst();
        int     op_t [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        longint a0 [8] = '{5, -6, 12, 9, 131071, 100, -7, 1};
        longint b0 [8] = '{7, 11, -3, 9, 131071, 100, -7, -1};
        longint c0 [8] = '{1000, 500, 40, 7, 0, -10000, -1, 999};
        longint e0 [8] = '{35, 434, 76, -81, 64'sd17179607041, 0, -50, 1};
        longint a1 [8] = '{-3, 2, 4, -8, -131072, -1, 0, 300};
        longint b1 [8] = '{9, 2, 5, 3, 131071, 1, 123, 200};
        longint c1 [8] = '{0, -10, 20, 1, 0, 5, 77, 0};
        longint e1 [8] = '{-27, -6, 0, 24, -64'sd17179738112, 4, 77, -60000};
        logic [CLIENTS_N-1:0] want_ack;
        client_cycle[1] = 1'b1;
        tick();
        checks++; if (client_stall[1] !== 1'b0) begin errors++; $display("FAIL burst_grant: got stall=%b want 0", client_stall[1]); end
        for (int k = 0; k < 8 + LAT; k++) begin
            if (k < 8) begin
                set_req(1, op_t[k], a0[k], b0[k], c0[k], a1[k], b1[k], c1[k]);
                client_strobe[1] = 1'b1;
            end else begin
                client_strobe[1] = 1'b0;
            end
            tick();
            want_ack = (k >= LAT - 1 && k < 8 + LAT - 1) ? 4'b0010 : 4'b0000;
            checks++; if (client_ack !== want_ack) begin errors++; $display("FAIL burst_ack[%0d]: got %b want %b", k, client_ack, want_ack); end
            if (want_ack[1]) begin
                checks++; if (p_of(1, 0) !== P_W'(e0[k-LAT+1])) begin errors++; $display("FAIL burst_p0[%0d]: got %0d want %0d", k-LAT+1, $signed(p_of(1, 0)), e0[k-LAT+1]); end
                checks++; if (p_of(1, 1) !== P_W'(e1[k-LAT+1])) begin errors++; $display("FAIL burst_p1[%0d]: got %0d want %0d", k-LAT+1, $signed(p_of(1, 1)), e1[k-LAT+1]); end
            end
        end
        client_cycle[1] = 1'b0;
        tick(); tick();
        checks++; if (lanes_busy !== 2'b00) begin errors++; $display("FAIL burst_release: got %b want 00", lanes_busy); end
    endtask

    task automatic test_drop();
        client_cycle[3] = 1'b1;
        tick();
        checks++; if (client_stall[3] !== 1'b0 || lanes_busy !== 2'b01) begin errors++; $display("FAIL drop_grant: got stall=%b busy=%b want 0/01", client_stall[3], lanes_busy); end
        set_req(3, 0, 2, 2, 0, 3, 3, 0);
        client_strobe[3] = 1'b1;
        tick(); tick();
        client_strobe[3] = 1'b0;
        client_cycle[3]  = 1'b0;
        client_cycle[0]  = 1'b1;
        tick();
        checks++; if (client_ack !== 4'h0) begin errors++; $display("FAIL drop_stale_ack0: got %b want 0000", client_ack); end
        checks++; if (lanes_busy !== 2'b11 || client_stall[0] !== 1'b0) begin errors++; $display("FAIL drop_other_grant: got busy=%b stall0=%b want 11/0", lanes_busy, client_stall[0]); end
        client_cycle[3] = 1'b1;
        tick();
        checks++; if (client_ack !== 4'h0 || client_stall[3] !== 1'b1) begin errors++; $display("FAIL drop_stale_ack1: got ack=%b stall3=%b want 0000/1", client_ack, client_stall[3]); end
        tick();
        checks++; if (client_ack !== 4'h0 || lanes_busy !== 2'b11) begin errors++; $display("FAIL drop_draining: got ack=%b busy=%b want 0000/11", client_ack, lanes_busy); end
        tick();
        checks++; if (lanes_busy !== 2'b10 || client_stall[3] !== 1'b1) begin errors++; $display("FAIL drop_freed: got busy=%b stall3=%b want 10/1", lanes_busy, client_stall[3]); end
        tick();
        checks++; if (lanes_busy !== 2'b11 || client_stall[3] !== 1'b0) begin errors++; $display("FAIL drop_regrant: got busy=%b stall3=%b want 11/0", lanes_busy, client_stall[3]); end
        set_req(3, 0, 2, 3, 0, -5, 4, 0);
        client_strobe[3] = 1'b1;
        tick();
        client_strobe[3] = 1'b0;
        tick(); tick();
        checks++; if (client_ack !== 4'b1000) begin errors++; $display("FAIL regrant_ack: got %b want 1000", client_ack); end
        checks++; if (p_of(3, 0) !== 48'd6 || p_of(3, 1) !== P_W'(-20)) begin errors++; $display("FAIL regrant_p: got %0d,%0d want 6,-20", $signed(p_of(3, 0)), $signed(p_of(3, 1))); end
        client_cycle = '0;
        tick(); tick();
        checks++; if (lanes_busy !== 2'b00) begin errors++; $display("FAIL drop_release: got %b want 00", lanes_busy); end
    endtask

    task automatic test_wrap();
        longint big = (longint'(1) <<< 47);
        logic [P_W-1:0] want0, want1;
        int n;
`ifdef DSP_POOL_SATURATE_EN
        want0 = 48'h7FFF_FFFF_FFFF;
        want1 = 48'h8000_0000_0000;
`else
        want0 = 48'h8003_FFFF_FFFF;
        want1 = 48'h7FFC_0002_0000;
`endif
        client_cycle[0] = 1'b1;
        tick();
        set_req(0, 1, -131072, -131072, big - 1, 131071, -131072, -big);
        client_strobe[0] = 1'b1;
        tick();
        client_strobe[0] = 1'b0;
        n = 0;
        while (n < 8 && client_ack[0] !== 1'b1) begin
            tick();
            n++;
        end
        checks++; if (n !== DEPTH - 1) begin errors++; $display("FAIL wrap_latency: got %0d cycles after accept edge want %0d", n, DEPTH - 1); end
        checks++; if (p_of(0, 0) !== want0) begin errors++; $display("FAIL wrap_p_ch0: got %h want %h", p_of(0, 0), want0); end
        checks++; if (p_of(0, 1) !== want1) begin errors++; $display("FAIL wrap_p_ch1: got %h want %h", p_of(0, 1), want1); end
        client_cycle = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        client_cycle[2] = 1'b1;
        tick();
        set_req(2, 1, 7, 7, 1, 2, 2, 2);
        client_strobe[2] = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++; if (client_ack !== 4'h0) begin errors++; $display("FAIL rst_mid_ack: got %b want 0000", client_ack); end
        checks++; if (client_stall !== 4'hF || lanes_busy !== 2'b00) begin errors++; $display("FAIL rst_mid_state: got stall=%b busy=%b want 1111/00", client_stall, lanes_busy); end
        checks++; if (client_p !== '0) begin errors++; $display("FAIL rst_mid_p: got %h want 0", client_p); end
        reset = 1'b0;
        client_cycle  = '0;
        client_strobe = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (client_ack !== 4'h0 || lanes_busy !== 2'b00) begin errors++; $display("FAIL rst_post[%0d]: got ack=%b busy=%b want 0000/00", k, client_ack, lanes_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_burst();
        test_drop();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
